// File: rtl/ascii_hex_frame_collector_if.sv
// rtl/ascii_hex_frame_collector_if.sv - character-in / frame-out bundle for the ASCII hex frame collector
interface ascii_hex_frame_collector_if #(
  parameter int NUM_BYTES = 2
);
  localparam int NUM_CHARS = NUM_BYTES * 2;

  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [NUM_CHARS*8-1:0] ascii_out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   frame_err;
  logic                   overrun;

  modport master (
    output rx_data, rx_valid, out_ready,
    input  ascii_out, out_valid, frame_err, overrun
  );

  modport slave (
    input  rx_data, rx_valid, out_ready,
    output ascii_out, out_valid, frame_err, overrun
  );
endinterface

// File: rtl/ascii_hex_frame_collector.sv
// rtl/ascii_hex_frame_collector.sv - gathers NUM_BYTES*2 ASCII hex chars + CR/LF into a packed frame
// Optional macro ASCII_HEX_LOWERCASE_EN accepts a-f and stores them as A-F.
module ascii_hex_frame_collector #(
  parameter int NUM_BYTES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  ascii_hex_frame_collector_if.slave bus
);
  localparam int NUM_CHARS = NUM_BYTES * 2;
  localparam int W         = NUM_CHARS * 8;
  localparam int CW        = $clog2(NUM_CHARS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHARS - 1);
  localparam logic [W-1:0]  ZERO_FRAME = {NUM_CHARS{8'h30}};

  typedef enum logic [1:0] {COLLECT, WAIT_EOL, DISCARD, FULL} state_t;

  state_t        state;
  logic [W-1:0]  buf_q;
  logic [CW-1:0] cnt;
  logic          is_hex;
  logic          is_eol;
  logic [7:0]    ch;
  logic          take;

  always_comb begin
    ch     = bus.rx_data;
    is_eol = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    is_hex = ((bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39)) ||
             ((bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h46));
`ifdef ASCII_HEX_LOWERCASE_EN
    if ((bus.rx_data >= 8'h61) && (bus.rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      ch     = bus.rx_data & 8'hDF;
    end
`endif
  end

  // A strobe arriving in FULL together with out_ready starts the next line immediately.
  assign take = bus.rx_valid && ((state == COLLECT) || ((state == FULL) && bus.out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      buf_q         <= ZERO_FRAME;
      cnt           <= '0;
      bus.ascii_out <= ZERO_FRAME;
      bus.out_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      case (state)
        COLLECT, FULL: begin
          if (state == FULL) begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              state         <= COLLECT;
            end else if (bus.rx_valid) begin
              bus.overrun <= 1'b1;
            end
          end
          if (take) begin
            if (is_hex) begin
              buf_q <= {buf_q[W-9:0], ch};
              cnt   <= cnt + 1'b1;
              if (cnt == LAST_IDX) begin
                state <= WAIT_EOL;
              end
            end else if (is_eol) begin
              if (cnt != '0) begin
                bus.frame_err <= 1'b1;
                cnt           <= '0;
              end
            end else begin
              bus.frame_err <= 1'b1;
              cnt           <= '0;
              state         <= DISCARD;
            end
          end
        end
        WAIT_EOL: begin
          if (bus.rx_valid) begin
            cnt <= '0;
            if (is_eol) begin
              bus.ascii_out <= buf_q;
              bus.out_valid <= 1'b1;
              state         <= FULL;
            end else begin
              bus.frame_err <= 1'b1;
              state         <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (bus.rx_valid && is_eol) begin
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_ascii_hex_frame_collector.sv
// tb/tb_ascii_hex_frame_collector.sv - vector table plus randomized line-level model check
module tb_ascii_hex_frame_collector;
`ifdef ASCII_HEX_LOWERCASE_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif
  localparam logic [31:0] Z   = 32'h30303030;
  localparam logic [31:0] F1  = 32'h31413242;
  localparam logic [31:0] FF  = 32'h46464646;
  localparam logic [31:0] F5  = 32'h35363738;
  localparam logic [31:0] FC  = 32'h43444546;
  localparam logic [31:0] LCO = LC ? 32'h41423031 : F5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascii_hex_frame_collector_if #(.NUM_BYTES(2)) bus ();

  ascii_hex_frame_collector #(.NUM_BYTES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          r;
    bit          v;
    logic [7:0]  d;
    bit          rdy;
    bit          ov;
    bit          fe;
    bit          orun;
    logic [31:0] out;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  // line-level reference model
  logic [7:0]  line[$];
  bit          disc;
  bit          m_valid;
  logic [31:0] m_out;
  bit          m_fe;
  bit          m_or;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit v, input logic [7:0] d, input bit rdy,
                     input bit ov, input bit fe, input bit orun, input logic [31:0] out);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.rdy = rdy;
    t.ov = ov; t.fe = fe; t.orun = orun; t.out = out;
    vecs.push_back(t);
  endtask

  task automatic chr(input logic [7:0] d, input bit ov, input bit fe, input logic [31:0] out);
    add(1'b0, 1'b1, d, 1'b0, ov, fe, 1'b0, out);
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit rdy);
    @(negedge clk);
    rst          = r;
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic bit hex_char(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (LC && c >= "a" && c <= "f");
  endfunction

  task automatic model_process(input logic [7:0] c);
    logic [31:0] p;
    if (c == 8'h0D || c == 8'h0A) begin
      if (disc) disc = 1'b0;
      else if (line.size() == 4) begin
        p = '0;
        foreach (line[i]) p = {p[23:0], line[i]};
        m_out   = p;
        m_valid = 1'b1;
        line.delete();
      end else if (line.size() != 0) begin
        m_fe = 1'b1;
        line.delete();
      end
    end else if (!disc) begin
      if (!hex_char(c) || line.size() == 4) begin
        m_fe = 1'b1;
        disc = 1'b1;
        line.delete();
      end else begin
        line.push_back((c >= "a") ? (c - 8'h20) : c);
      end
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit rdy);
    bit proc;
    m_fe = 1'b0;
    m_or = 1'b0;
    if (r) begin
      line.delete();
      disc = 1'b0; m_valid = 1'b0; m_out = Z;
    end else begin
      proc = v;
      if (m_valid) begin
        if (rdy) m_valid = 1'b0;
        else begin
          if (v) m_or = 1'b1;
          proc = 1'b0;
        end
      end
      if (proc) model_process(d);
    end
  endtask

  function automatic logic [7:0] rand_char();
    int k;
    logic [7:0] digits [16];
    digits = '{"0","1","2","3","4","5","6","7","8","9","A","B","C","D","E","F"};
    k = $urandom_range(0, 99);
    if (k < 60) return digits[$urandom_range(0, 15)];
    if (k < 68) return 8'(8'h61 + $urandom_range(0, 5));
    if (k < 85) return ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.out_ready = 1'b0;

    add(1, 0, 8'h00, 0, 0, 0, 0, Z);
    // 1A2B CR, hold, accept
    chr("1", 0, 0, Z); chr("A", 0, 0, Z); chr("2", 0, 0, Z); chr("B", 0, 0, Z);
    chr(8'h0D, 1, 0, F1);
    add(0, 0, 8'h00, 0, 1, 0, 0, F1);
    add(0, 0, 8'h00, 1, 0, 0, 0, F1);
    // LF ignored, short line errors
    chr(8'h0A, 0, 0, F1); chr("1", 0, 0, F1); chr("2", 0, 0, F1);
    chr(8'h0D, 0, 1, F1);
    add(0, 0, 8'h00, 1, 0, 0, 0, F1);
    // bad char discards rest of line
    chr("1", 0, 0, F1); chr("G", 0, 1, F1); chr("2", 0, 0, F1); chr("B", 0, 0, F1);
    chr(8'h0D, 0, 0, F1);
    chr("F", 0, 0, F1); chr("F", 0, 0, F1); chr("F", 0, 0, F1); chr("F", 0, 0, F1);
    chr(8'h0D, 1, 0, FF);
    // overrun, then same-cycle accept starts next frame
    add(0, 1, "5", 0, 1, 0, 1, FF);
    add(0, 1, "5", 1, 0, 0, 0, FF);
    chr("6", 0, 0, FF); chr("7", 0, 0, FF); chr("8", 0, 0, FF);
    chr(8'h0D, 1, 0, F5);
    add(0, 0, 8'h00, 1, 0, 0, 0, F5);
    // too long
    chr("1", 0, 0, F5); chr("2", 0, 0, F5); chr("3", 0, 0, F5); chr("4", 0, 0, F5);
    chr("5", 0, 1, F5); chr(8'h0D, 0, 0, F5);
    // lowercase
    chr("a", 0, !LC, F5); chr("b", 0, 0, F5); chr("0", 0, 0, F5); chr("1", 0, 0, F5);
    chr(8'h0D, LC, 0, LCO);
    add(0, 0, 8'h00, 1, 0, 0, 0, LCO);
    // reset mid-frame and while full
    chr("1", 0, 0, LCO); chr("A", 0, 0, LCO);
    add(1, 0, 8'h00, 0, 0, 0, 0, Z);
    chr("C", 0, 0, Z); chr("D", 0, 0, Z); chr("E", 0, 0, Z); chr("F", 0, 0, Z);
    chr(8'h0D, 1, 0, FC);
    add(1, 0, 8'h00, 0, 0, 0, 0, Z);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].rdy);
      check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
      check($sformatf("vec%0d frame_err", i), 32'(bus.frame_err), 32'(vecs[i].fe));
      check($sformatf("vec%0d overrun", i),   32'(bus.overrun),   32'(vecs[i].orun));
      check($sformatf("vec%0d ascii_out", i), bus.ascii_out,      vecs[i].out);
    end

    model_step(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      bit         r, v, rdy;
      logic [7:0] d;
      r   = ($urandom_range(0, 399) == 0);
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 3);
      d   = rand_char();
      model_step(r, v, d, rdy);
      drive(r, v, d, rdy);
      check($sformatf("rnd%0d out_valid", n), 32'(bus.out_valid), 32'(m_valid));
      check($sformatf("rnd%0d frame_err", n), 32'(bus.frame_err), 32'(m_fe));
      check($sformatf("rnd%0d overrun", n),   32'(bus.overrun),   32'(m_or));
      check($sformatf("rnd%0d ascii_out", n), bus.ascii_out,      m_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ascii_hex_frame_collector.md
# ascii_hex_frame_collector

Collects a stream of ASCII hex characters from the UART receiver into a fixed-width frame of `NUM_BYTES*2` characters and presents it as a packed vector to the ASCII-to-hex translation stage. A frame is exactly `NUM_BYTES*2` hex digits terminated by CR or LF. Malformed lines are discarded with an error pulse. The first character received becomes the most significant nibble.

## Interface
- `NUM_BYTES`, default 2: raw bytes per frame. `NUM_CHARS = NUM_BYTES*2` characters per frame.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received character from the UART; valid only when `rx_valid` = 1.
- `rx_valid`  in  1  one-cycle strobe per received character. No backpressure is possible.
- `ascii_out`  out  `NUM_CHARS*8`  completed frame. Character k (0 = last received) sits at `[k*8 +: 8]`.
- `out_valid`  out  1  frame available; held until it is accepted.
- `out_ready`  in  1  downstream accepts the frame when `out_valid & out_ready`.
- `frame_err`  out  1  one-cycle pulse when a malformed line is detected.
- `overrun`  out  1  one-cycle pulse when a character is dropped because the output is full.

## Operation
- Character classes:
  - HEX: `0x30–0x39` and `0x41–0x46`. With the macro enabled, also `0x61–0x66`.
  - EOL: `0x0D` or `0x0A`.
  - BAD: everything else.
- Internal shift buffer of `NUM_CHARS*8` bits. On storing a character: `buf <= {buf[NUM_CHARS*8-9:0], ch}`.
- Character counter `cnt` runs from 0 to `NUM_CHARS`, width `$clog2(NUM_CHARS+1)`.
- FSM states and transitions:
  - COLLECT (reset state). Transitions apply only when `rx_valid` = 1.
    - HEX: store the character and increment `cnt`. When `cnt` reaches `NUM_CHARS`, go to WAIT_EOL.
    - EOL with `cnt` = 0: ignored. This makes CRLF and blank lines harmless.
    - EOL with `cnt` > 0: pulse `frame_err`, clear `cnt`, stay in COLLECT.
    - BAD: pulse `frame_err`, clear `cnt`, go to DISCARD.
  - WAIT_EOL
    - EOL: load `ascii_out <= buf`, set `out_valid`, clear `cnt`, go to FULL.
    - HEX or BAD: pulse `frame_err`, clear `cnt`, go to DISCARD. The frame is too long.
  - DISCARD
    - All characters are dropped until an EOL arrives, then go to COLLECT.
    - No further `frame_err` pulses for the same line.
  - FULL
    - `ascii_out` and `out_valid` are held stable.
    - On `out_valid & out_ready`: clear `out_valid` and go to COLLECT.
    - `rx_valid` without `out_ready`: drop the character and pulse `overrun`.
    - `rx_valid` together with `out_ready` in the same cycle: the character is processed exactly as in COLLECT with `cnt` = 0, and no overrun is raised.
- `ascii_out` changes only on a frame load. It is never altered while `out_valid` = 1.

## Timing
- Reset values:
  - Outputs: `out_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - `ascii_out` = all characters `0x30` (ASCII '0'), so the downstream stage decodes to zero.
  - Internals: `buf` = all `0x30`, `cnt` = 0, state COLLECT.
- Latency: terminating EOL strobe in cycle N → `out_valid` = 1 and `ascii_out` updated in cycle N+1.
- `frame_err` and `overrun` are high for exactly the cycle after the offending strobe.
- Throughput: one character per cycle. Back-to-back `rx_valid` strobes are legal.
- Reset asserted mid-frame or while FULL: all state returns to reset values on the next edge. The pending frame is lost and no error pulse is raised.
- `out_ready` is ignored when `out_valid` = 0.

## Configuration
- Macro: `ASCII_HEX_LOWERCASE_EN`.
- Defined:
  - `a`–`f` (`0x61–0x66`) are accepted as HEX.
  - They are normalised to uppercase (bit 5 cleared) before storage, so `ascii_out` contains only `0–9` and `A–F`.
- Undefined: `0x61–0x66` are BAD and cause `frame_err`.

## Test plan
- `NUM_BYTES`=2, send `1A2B\r` → one cycle after CR: `out_valid`=1, `ascii_out`=`0x31413242`. Holds with `out_ready`=0; drops one cycle after `out_ready`=1.
- Send `1A2B\r\n12\r` → one frame only; LF ignored. `12\r` gives one `frame_err` pulse and no `out_valid`.
- Send `1G2B\r` then `FFFF\r` → one `frame_err` on `G`, rest of the line discarded; next frame `ascii_out`=`0x46464646`.
- Send `ab01\r`: with macro → `ascii_out`=`0x41423031`; without macro → `frame_err`, no frame.
- Frame in FULL with `out_ready`=0, send `5` → `overrun` pulse, frame unchanged. Repeat with `out_ready`=1 in the same cycle as `5` → no overrun, and `5` is the first character of the next frame.
- Send `1A` then assert `rst` for one cycle, then `CDEF\r` → `ascii_out`=`0x43444546`, no `frame_err`. Immediately after reset: `ascii_out`=`0x30303030`, `out_valid`=0.
